// File: rtl/pc_sequencer_if.sv
// Bundle of phase strobes, decoded-instruction inputs and branch/stack results
// exchanged between the instruction decoder/program counter and pc_sequencer.
interface pc_sequencer_if #(
    parameter int N = 9
);
    logic         q3;
    logic         q4;
    logic [N-1:0] pc;
    logic         dec_goto;
    logic         dec_call;
    logic         dec_retlw;
    logic         dec_pcl_wr;
    logic         dec_skip;
    logic [8:0]   lit;
    logic [7:0]   pcl_data;
    logic [N-1:0] goto_addr;
    logic         goto_enable;
    logic         skip;
    logic         suppress;
    logic [1:0]   stack_depth;
    logic         stack_err;

    modport master (
        output q3, q4, pc, dec_goto, dec_call, dec_retlw, dec_pcl_wr, dec_skip, lit, pcl_data,
        input  goto_addr, goto_enable, skip, suppress, stack_depth, stack_err
    );

    modport slave (
        input  q3, q4, pc, dec_goto, dec_call, dec_retlw, dec_pcl_wr, dec_skip, lit, pcl_data,
        output goto_addr, goto_enable, skip, suppress, stack_depth, stack_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Branch/skip sequencer for a PIC-style core: resolves GOTO/CALL/RETLW/PCL writes
// and skips at Q3, drives the PC load at Q4, and keeps a two-entry return stack.
module pc_sequencer #(
    parameter int L2_PIC_INSTR_MEM_DEPTH = 9
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);
    localparam int N = L2_PIC_INSTR_MEM_DEPTH;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_GOTO,
        ACT_CALL,
        ACT_RETLW,
        ACT_PCL,
        ACT_SKIP
    } action_e;

    action_e      action;
    logic         branch;
    logic [N-1:0] target;

    logic [N-1:0] goto_addr_q;
    logic         goto_enable_q;
    logic         skip_q;
    logic         suppress_q;
    logic [1:0]   depth_q;
    logic         err_q;
    logic [N-1:0] tos_q;
    logic [N-1:0] s1_q;

    // NOTE: every variable gets a default before the if/case chain, otherwise
    // any path that skips an assignment infers a latch.
    always_comb begin
        action = ACT_NONE;
        target = '0;
        if (bus.dec_goto) begin
            action = ACT_GOTO;
            target = N'(bus.lit);
        end else if (bus.dec_call) begin
            action = ACT_CALL;
            target = N'(bus.lit[7:0]);
        end else if (bus.dec_retlw) begin
            action = ACT_RETLW;
            target = tos_q;
        end else if (bus.dec_pcl_wr) begin
            action = ACT_PCL;
            target = N'(bus.pcl_data);
        end else if (bus.dec_skip) begin
            action = ACT_SKIP;
        end
        branch = (action != ACT_NONE) && (action != ACT_SKIP);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            goto_addr_q   <= '0;
            goto_enable_q <= 1'b0;
            skip_q        <= 1'b0;
            suppress_q    <= 1'b0;
            depth_q       <= 2'd0;
            err_q         <= 1'b0;
            // NOTE: the stack registers are reset because a pop from an empty
            // stack exposes the stale TOS value, which must be deterministic.
            tos_q         <= '0;
            s1_q          <= '0;
        end else begin
            // A taken branch at Q4 arms suppress for exactly one instruction.
            if (bus.q4) begin
                goto_addr_q   <= '0;
                goto_enable_q <= 1'b0;
                skip_q        <= 1'b0;
                suppress_q    <= goto_enable_q;
            end
            if (bus.q3 && !suppress_q) begin
                goto_enable_q <= branch;
                skip_q        <= (action == ACT_SKIP);
                goto_addr_q   <= branch ? target : '0;
                if (action == ACT_CALL) begin
                    s1_q  <= tos_q;
                    tos_q <= bus.pc + N'(1);
                    if (depth_q == 2'd2) err_q <= 1'b1;
                    else                 depth_q <= depth_q + 2'd1;
                end
                if (action == ACT_RETLW) begin
                    tos_q <= s1_q;
                    if (depth_q == 2'd0) err_q <= 1'b1;
                    else                 depth_q <= depth_q - 2'd1;
                end
            end
        end
    end

    assign bus.goto_addr   = goto_addr_q;
    assign bus.goto_enable = goto_enable_q;
    assign bus.skip        = skip_q;
    assign bus.suppress    = suppress_q;
    assign bus.stack_depth = depth_q;
    assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random instruction
// streams, compared against a behavioural model of the stack and branch rules.
module tb_pc_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pc_sequencer_if #(.N(9)) bus ();

    pc_sequencer #(.L2_PIC_INSTR_MEM_DEPTH(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: return stack as a two-slot list, front = top of stack.
    logic [8:0] stk[$];
    int         depth_m;
    bit         err_m;
    bit         sup_m;

    task automatic model_reset();
        stk     = {9'd0, 9'd0};
        depth_m = 0;
        err_m   = 1'b0;
        sup_m   = 1'b0;
    endtask

    task automatic model_push(input logic [8:0] v);
        stk = {v, stk[0]};
        if (depth_m == 2) err_m = 1'b1;
        else depth_m++;
    endtask

    task automatic model_pop(output logic [8:0] v);
        v   = stk[0];
        stk = {stk[1], stk[1]};
        if (depth_m == 0) err_m = 1'b1;
        else depth_m--;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input bit g, c, r, p, s, input logic [8:0] l, pcv, input logic [7:0] pd);
        bus.dec_goto   = g;
        bus.dec_call   = c;
        bus.dec_retlw  = r;
        bus.dec_pcl_wr = p;
        bus.dec_skip   = s;
        bus.lit        = l;
        bus.pc         = pcv;
        bus.pcl_data   = pd;
    endtask

    task automatic noise();
        set_dec(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                9'($urandom), 9'($urandom), 8'($urandom));
    endtask

    task automatic check_state(input string ph, input logic [8:0] ea, input bit een, esk);
        check({ph, "_goto_enable"}, 32'(bus.goto_enable), 32'(een));
        check({ph, "_skip"},        32'(bus.skip),        32'(esk));
        check({ph, "_goto_addr"},   32'(bus.goto_addr),   32'(ea));
        check({ph, "_suppress"},    32'(bus.suppress),    32'(sup_m));
        check({ph, "_depth"},       32'(bus.stack_depth), 32'(depth_m));
        check({ph, "_err"},         32'(bus.stack_err),   32'(err_m));
    endtask

    // One Q1..Q4 instruction cycle; decode lines carry junk outside Q3.
    task automatic instr(input bit g, c, r, p, s, input logic [8:0] l, pcv,
                         input logic [7:0] pd, input bit rst_q4);
        logic [8:0] ea;
        bit         een;
        bit         esk;
        bus.q3 = 1'b0; bus.q4 = 1'b0; noise();
        tick();
        noise();
        tick();
        bus.q3 = 1'b1;
        set_dec(g, c, r, p, s, l, pcv, pd);
        tick();
        ea = 9'd0; een = 1'b0; esk = 1'b0;
        if (!sup_m) begin
            if (g) begin
                ea = l; een = 1'b1;
            end else if (c) begin
                ea = {1'b0, l[7:0]}; een = 1'b1; model_push(pcv + 9'd1);
            end else if (r) begin
                model_pop(ea); een = 1'b1;
            end else if (p) begin
                ea = {1'b0, pd}; een = 1'b1;
            end else if (s) begin
                esk = 1'b1;
            end
        end
        bus.q3 = 1'b0; bus.q4 = 1'b1; rst = rst_q4; noise();
        check_state("q4", ea, een, esk);
        tick();
        bus.q4 = 1'b0; rst = 1'b0;
        if (rst_q4) model_reset();
        else sup_m = een;
        check_state("q1", 9'd0, 1'b0, 1'b0);
    endtask

    task automatic nop();
        instr(0, 0, 0, 0, 0, 9'h0, 9'h0, 8'h0, 0);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; bus.q3 = 1'b0; bus.q4 = 1'b0;
        set_dec(0, 0, 0, 0, 0, 9'h0, 9'h0, 8'h0);
        model_reset();
        tick(); tick();
        rst = 1'b0;
        check_state("reset", 9'd0, 1'b0, 1'b0);

        // CALL from 0x010 with lit 0x155: target 0x055, TOS 0x011
        instr(0, 1, 0, 0, 0, 9'h155, 9'h010, 8'h00, 0);
        nop();
        instr(0, 1, 0, 0, 0, 9'h0A3, 9'h060, 8'h00, 0);
        nop();
        instr(0, 0, 1, 0, 0, 9'h000, 9'h0A3, 8'h00, 0);
        nop();
        instr(0, 0, 1, 0, 0, 9'h000, 9'h062, 8'h00, 0);
        nop();

        // Overflow then underflow
        instr(0, 1, 0, 0, 0, 9'h011, 9'h100, 8'h00, 0); nop();
        instr(0, 1, 0, 0, 0, 9'h022, 9'h1FF, 8'h00, 0); nop();
        instr(0, 1, 0, 0, 0, 9'h033, 9'h0FE, 8'h00, 0); nop();
        for (int i = 0; i < 3; i++) begin
            instr(0, 0, 1, 0, 0, 9'h000, 9'h000, 8'h00, 0); nop();
        end

        rst = 1'b1; tick(); rst = 1'b0; model_reset();
        check_state("rst2", 9'd0, 1'b0, 1'b0);

        // GOTO beats skip; PCL write; skip alone; GOTO under suppress
        instr(1, 0, 0, 0, 1, 9'h1A0, 9'h000, 8'h00, 0); nop();
        instr(0, 0, 0, 1, 1, 9'h1FF, 9'h000, 8'hC7, 0); nop();
        instr(0, 0, 0, 0, 1, 9'h1FF, 9'h000, 8'h00, 0);
        instr(1, 0, 0, 0, 0, 9'h0F0, 9'h000, 8'h00, 0);
        instr(1, 0, 0, 0, 0, 9'h10F, 9'h000, 8'h00, 0);
        nop();

        // Reset during Q4 of a pending CALL
        instr(0, 1, 0, 0, 0, 9'h077, 9'h040, 8'h00, 1);
        nop();

        for (int i = 0; i < 400; i++) begin
            instr($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
                  $urandom_range(4) == 0, $urandom_range(2) == 0,
                  9'($urandom), 9'($urandom), 8'($urandom), $urandom_range(39) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: L2_PIC_INSTR_MEM_DEPTH, default 9, program-address width (N below).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 q3  input  1  Q3 phase strobe from the program counter.
REQ-005 q4  input  1  Q4 phase strobe from the program counter.
REQ-006 pc  input  N  address of the instruction currently executing.
REQ-007 dec_goto  input  1  decoded GOTO.
REQ-008 dec_call  input  1  decoded CALL.
REQ-009 dec_retlw  input  1  decoded RETLW.
REQ-010 dec_pcl_wr  input  1  current instruction writes PCL.
REQ-011 dec_skip  input  1  skip-type instruction (BTFSC/BTFSS/DECFSZ/INCFSZ) whose skip condition is true.
REQ-012 lit  input  9  instruction literal field (GOTO: 9 bits; CALL: lit[7:0]).
REQ-013 pcl_data  input  8  ALU result written to PCL.
REQ-014 goto_addr  output  N  branch target to the program counter.
REQ-015 goto_enable  output  1  load goto_addr at Q4.
REQ-016 skip  output  1  advance PC by 2 at Q4.
REQ-017 suppress  output  1  high for the whole instruction cycle following a taken branch; the decoder forces that instruction to a NOP.
REQ-018 stack_depth  output  2  number of valid stack entries (0..2).
REQ-019 stack_err  output  1  sticky; set on push while full or pop while empty.

Function
REQ-020 Decode inputs are sampled only on the clk edge where q3=1; they are ignored in all other phases.
REQ-021 goto_enable, skip and goto_addr are registered: they are set on the q3 sample edge, valid throughout the q4 cycle, and cleared on the edge where q4=1.
REQ-022 Action priority when several dec_* are high: goto > call > retlw > pcl_wr > skip; exactly one action is taken.
REQ-023 GOTO: goto_addr = lit[N-1:0]; goto_enable=1.
REQ-024 CALL: goto_addr = {0, lit[7:0]} (bit 8 forced 0); push (pc+1) mod 2^N; goto_enable=1.
REQ-025 RETLW: goto_addr = top of stack; pop; goto_enable=1.
REQ-026 PCL write: goto_addr = {0, pcl_data}; goto_enable=1.
REQ-027 Skip: skip=1, goto_enable=0; suppress is not asserted.
REQ-028 Stack: two entries TOS/S1. Push: S1<=TOS, TOS<=value; at depth 2 the old S1 is lost, depth stays 2, stack_err set.
REQ-029 Pop: returns TOS; TOS<=S1, S1 unchanged; at depth 0 TOS is still returned (stale value), depth stays 0, stack_err set.
REQ-030 Stack and depth update on the q3 sample edge.
REQ-031 suppress is set on the q4 edge of a cycle with goto_enable=1 and cleared on the next q4 edge (exactly 4 clk).
REQ-032 While suppress=1, decode inputs are ignored: no action, no stack change, all outputs except suppress held 0.
REQ-033 Instruction cycles are Q1..Q4; rst mid-cycle aborts any pending action and does not alter the stack after rst deasserts.

Reset
REQ-034 On rst: goto_addr=0, goto_enable=0, skip=0, suppress=0, stack_depth=0, stack_err=0, TOS=S1=0.
REQ-035 Reset has priority over all other inputs in the same cycle.

Verification
REQ-036 pc=0x010, dec_call, lit=0x155 at q3 -> q4 cycle: goto_enable=1, goto_addr=0x055; depth=1, TOS=0x011; suppress=1 next cycle.
REQ-037 Two CALLs (TOS 0x011, then 0x061), then RETLW twice -> goto_addr 0x061 then 0x011; depth 2->1->0; stack_err=0.
REQ-038 Third CALL at depth 2 -> depth stays 2, oldest entry lost, stack_err=1; RETLW at depth 0 -> stack_err stays 1.
REQ-039 dec_goto and dec_skip together, lit=0x1A0 -> goto_enable=1, goto_addr=0x1A0, skip=0.
REQ-040 dec_skip true -> skip=1 for q4 cycle only, suppress=0; dec_goto during a suppress cycle -> ignored.
REQ-041 rst asserted during q4 of a pending CALL -> all outputs 0, depth 0 on the next cycle.
